// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg
//   Shared constants for the nibble-serial add/subtract sequencer:
//   FSM state encodings, op encodings and the datapath nibble width.
//   Imported by addsub_nibble and nibble_serial_addsub_ctrl.
package addsub_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/addsub_nibble.sv
// addsub_nibble
//   Combinational 4-bit adder with carry-in. One instance is time-shared by
//   every pass of the sequencer. Subtraction is handled upstream by inverting
//   b and seeding cin, so this block only ever adds.
// Ports
//   a, b  : nibble operands
//   cin   : carry in
//   s     : nibble sum
//   cout  : carry out
module addsub_nibble
    import addsub_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
//   Sequences a WIDTH-bit add or subtract over one shared 4-bit adder, LSB
//   nibble first, one nibble per clock, with a registered carry between
//   passes. Result and carry-out are valid when done pulses.
//   Optional macro ADDSUB_OVF_FLAG_EN adds a signed-overflow output ovf.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, accepted when start && ready
//   op       : 0 add, 1 subtract (sampled on accept)
//   a, b     : operands (sampled on accept)
//   ready    : idle, can accept
//   busy     : running or presenting the result
//   sum      : result register (valid from done until next accept)
//   cout     : final carry; on subtract 1 means no borrow
//   done     : one-cycle result-valid pulse
//   ovf      : signed overflow (ADDSUB_OVF_FLAG_EN only)
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | waiting for start, ready=1
// ST_RUN  | one nibble processed per clock, idx counts up
// ST_DONE | result final, done=1 for this single cycle
module nibble_serial_addsub_ctrl
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
`ifdef ADDSUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic                carry_q;
    logic                op_r;
    logic [WIDTH-1:0]    a_r, b_r, b_eff, sum_q;
    logic                cout_q;
    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic                c_nib;
    logic                accept, last_nib;
    logic [IDX_W+1:0]    nib_off;

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_nib = (state_q == ST_RUN) && (idx_q == LAST_IDX);

    // Bit offset of the current nibble: idx * 4.
    assign nib_off = {idx_q, 2'b00};
    assign b_eff   = b_r ^ {WIDTH{op_r == OP_SUB}};
    assign a_nib   = a_r[nib_off +: NIBBLE_W];
    assign b_nib   = b_eff[nib_off +: NIBBLE_W];

    addsub_nibble u_nibble (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (c_nib)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
        done  = (state_q == ST_DONE);
    end

    // Sum is deliberately not cleared on accept; it holds the previous result
    // until the first nibble of the new op overwrites its low bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            carry_q <= op;   // the +1 of A + ~B + 1
            idx_q   <= '0;
        end else if (state_q == ST_RUN) begin
            sum_q[nib_off +: NIBBLE_W] <= s_nib;
            carry_q <= c_nib;
            idx_q   <= idx_q + 1'b1;
            if (last_nib) cout_q <= c_nib;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef ADDSUB_OVF_FLAG_EN
    logic ovf_q;

    // Carry into the MSB recovered from the MSB sum bit; overflow when it
    // disagrees with the carry out of the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ovf_q <= 1'b0;
        else if (last_nib) ovf_q <= (a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ s_nib[NIBBLE_W-1]) ^ c_nib;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb_nibble_serial_addsub_ctrl
//   Self-checking bench for nibble_serial_addsub_ctrl (WIDTH=16).
//   Expected results are queued when an op is launched and compared when
//   done pulses. Build with ADDSUB_OVF_FLAG_EN to also check ovf.
module tb_nibble_serial_addsub_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a, b;
    logic             ready, busy, done, cout;
    logic [WIDTH-1:0] sum;
`ifdef ADDSUB_OVF_FLAG_EN
    logic             ovf;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .sum   (sum),
        .cout  (cout),
        .done  (done)
`ifdef ADDSUB_OVF_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] ye;
        exp_t             r;
        ye     = o ? ~y : y;
        full   = {1'b0, x} + {1'b0, ye} + (WIDTH+1)'(o);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (x[WIDTH-1] == ye[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            check("done_width", {31'b0, prev_done}, 32'd0);
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sum", {16'b0, sum}, {16'b0, e.sum});
                check("cout", {31'b0, cout}, {31'b0, e.cout});
`ifdef ADDSUB_OVF_FLAG_EN
                check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
            end
        end
        prev_done <= done;
    end

    // Leaves the caller on a negedge with ready high (or reports a timeout).
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", {31'b0, ready}, 32'd1);
    endtask

    task automatic do_op(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] es, input logic ec);
        exp_t e;
        int   n;
        e      = model(o, x, y);
        e.sum  = es;
        e.cout = ec;
        wait_ready();
        start = 1'b1; op = o; a = x; b = y;
        sb_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        // n counts negedges from the one right after the accept edge
        check("latency", n - 1, NIB);
    endtask

    task automatic do_rand_op();
        logic [WIDTH-1:0] x, y;
        logic             o;
        exp_t             m;
        x = WIDTH'($urandom);
        y = WIDTH'($urandom);
        o = 1'($urandom_range(0, 1));
        m = model(o, x, y);
        do_op(o, x, y, m.sum, m.cout);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0;

        // basic add / sub / full ripple
        do_op(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0);
        do_op(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
        do_op(1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1);
        do_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);

        // start held high, operands changed mid-run
        wait_ready();
        start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
        sb_q.push_back(model(1'b0, 16'h1111, 16'h2222));
        @(posedge clk);
        #1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 2) begin
                op = 1'b1; a = 16'hAAAA; b = 16'h0101;
                sb_q.push_back(model(1'b1, 16'hAAAA, 16'h0101));
            end
            if (i == 3) check("t4_busy_run", {31'b0, ready}, 32'd0);
            if (i == 6) begin
                check("t4_gap_ready", {31'b0, ready}, 32'd1);
                check("t4_gap_busy", {31'b0, busy}, 32'd0);
            end
            if (i == 7) begin
                check("t4_reaccept", {31'b0, busy}, 32'd1);
                start = 1'b0;
            end
        end
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_second_done", {31'b0, done}, 32'd1);

        // reset during the second RUN cycle
        wait_ready();
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h1111;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum", {16'b0, sum}, 32'd0);
        check("abort_cout", {31'b0, cout}, 32'd0);
`ifdef ADDSUB_OVF_FLAG_EN
        check("abort_ovf", {31'b0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0);

        // signed-overflow corners (ovf compared only when the flag is built in)
        do_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        do_op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
        do_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
        do_op(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1);

        for (int i = 0; i < 10; i++) do_rand_op();

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
